// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives the
// ALU operation class, datapath mux selects and write enables per state.
// The memory states stretch while mem_ready is low.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t state, state_next;
  logic   pc_update;
  logic   branch;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of the combinational logic.
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Next-state and Moore outputs, with mem_ready gating and reset override.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    state_next = S_FETCH;
    ALUOp      = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem_ready;
        pc_update  = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target OldPC + imm while decoding.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        retire     = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        branch     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC <= branch target from DECODE; ALU forms the link OldPC + 4.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    // During reset, show FETCH selects and suppress every side effect.
    if (!rst_n) begin
      ALUOp     = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
    end

    PCWrite = pc_update | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm. Each task walks one
// instruction cycle by cycle and compares the full output vector against
// hand-written expected values.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal;

  int errors = 0;
  int checks = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {ALUOp,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,AdrSrc,IRWrite,PCWrite,RegWrite,MemWrite,retire,illegal}
  wire [16:0] obs = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
                     IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal};

  function automatic logic [16:0] v(
    input logic [1:0] aop, input logic [1:0] sa, input logic [1:0] sb,
    input logic [1:0] rs, input logic [1:0] imm, input logic adr,
    input logic ir, input logic pc, input logic rw, input logic mw,
    input logic ret, input logic ill);
    return {aop, sa, sb, rs, imm, adr, ir, pc, rw, mw, ret, ill};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0000000; zero = 1'b0;
    #1;
    checks++;
    if (obs !== v(2'b00,2'b00,2'b10,2'b10,2'b00,0,0,0,0,0,0,0)) begin
      errors++; $display("FAIL reset_hold0 obs=%b exp=%b", obs, v(2'b00,2'b00,2'b10,2'b10,2'b00,0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== v(2'b00,2'b00,2'b10,2'b10,2'b00,0,0,0,0,0,0,0)) begin
      errors++; $display("FAIL reset_hold1 obs=%b exp=%b", obs, v(2'b00,2'b00,2'b10,2'b10,2'b00,0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0)) begin
      errors++; $display("FAIL reset_release obs=%b exp=%b", obs, v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0));
    end
  endtask

  task automatic test_lw();
    logic [16:0] e [6];
    op = 7'b0000011;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0),   // FETCH
          v(2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0),   // DECODE
          v(2'b00,2'b10,2'b01,2'b00,2'b00,0,0,0,0,0,0,0),   // MEMADR
          v(2'b00,2'b00,2'b00,2'b00,2'b00,1,0,0,0,0,0,0),   // MEMREAD
          v(2'b00,2'b00,2'b00,2'b01,2'b00,0,0,0,1,0,1,0),   // MEMWB
          v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0)};  // FETCH
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL lw cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      if (i < 5) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_rtype();
    logic [16:0] e [5];
    op = 7'b0110011;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0),   // FETCH
          v(2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0),   // DECODE
          v(2'b10,2'b10,2'b00,2'b00,2'b00,0,0,0,0,0,0,0),   // EXECUTER
          v(2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,1,0,1,0),   // ALUWB
          v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0)};  // FETCH
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL rtype cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_itype();
    logic [16:0] e [5];
    op = 7'b0010011;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0),   // FETCH
          v(2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0),   // DECODE
          v(2'b10,2'b10,2'b01,2'b00,2'b00,0,0,0,0,0,0,0),   // EXECUTEI
          v(2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,1,0,1,0),   // ALUWB
          v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0)};  // FETCH
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL itype cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_beq(input logic z);
    logic [16:0] e [4];
    op = 7'b1100011; zero = z;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b10,0,1,1,0,0,0,0),   // FETCH
          v(2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0,0,0,0,0),   // DECODE
          v(2'b01,2'b10,2'b00,2'b00,2'b10,0,0,z,0,0,1,0),   // BEQ
          v(2'b00,2'b00,2'b10,2'b10,2'b10,0,1,1,0,0,0,0)};  // FETCH
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL beq_z%0b cyc%0d obs=%b exp=%b", z, i, obs, e[i]);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_stall();
    logic [16:0] e [10];
    logic        mr [10];
    op = 7'b0100011;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b01,0,0,0,0,0,0,0),   // FETCH stalled
          v(2'b00,2'b00,2'b10,2'b10,2'b01,0,0,0,0,0,0,0),   // FETCH stalled
          v(2'b00,2'b00,2'b10,2'b10,2'b01,0,1,1,0,0,0,0),   // FETCH ready
          v(2'b00,2'b01,2'b01,2'b00,2'b01,0,0,0,0,0,0,0),   // DECODE
          v(2'b00,2'b10,2'b01,2'b00,2'b01,0,0,0,0,0,0,0),   // MEMADR
          v(2'b00,2'b00,2'b00,2'b00,2'b01,1,0,0,0,1,0,0),   // MEMWRITE stalled
          v(2'b00,2'b00,2'b00,2'b00,2'b01,1,0,0,0,1,0,0),   // MEMWRITE stalled
          v(2'b00,2'b00,2'b00,2'b00,2'b01,1,0,0,0,1,0,0),   // MEMWRITE stalled
          v(2'b00,2'b00,2'b00,2'b00,2'b01,1,0,0,0,1,1,0),   // MEMWRITE ready
          v(2'b00,2'b00,2'b10,2'b10,2'b01,0,1,1,0,0,0,0)};  // FETCH (cycle 10)
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL sw_stall cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      if (i < 9) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_jal();
    logic [16:0] e [5];
    op = 7'b1101111;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b11,0,1,1,0,0,0,0),   // FETCH
          v(2'b00,2'b01,2'b01,2'b00,2'b11,0,0,0,0,0,0,0),   // DECODE
          v(2'b00,2'b01,2'b10,2'b00,2'b11,0,0,1,0,0,0,0),   // JAL
          v(2'b00,2'b00,2'b00,2'b00,2'b11,0,0,0,1,0,1,0),   // ALUWB
          v(2'b00,2'b00,2'b10,2'b10,2'b11,0,1,1,0,0,0,0)};  // FETCH
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL jal cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_illegal();
    logic [16:0] e [3];
    op = 7'b0000000;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0),   // FETCH
          v(2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,1),   // DECODE, illegal
          v(2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0)};  // FETCH
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL illegal cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [16:0] e [4];
    op = 7'b0100011;
    e = '{v(2'b00,2'b00,2'b10,2'b10,2'b01,0,1,1,0,0,0,0),   // FETCH
          v(2'b00,2'b01,2'b01,2'b00,2'b01,0,0,0,0,0,0,0),   // DECODE
          v(2'b00,2'b10,2'b01,2'b00,2'b01,0,0,0,0,0,0,0),   // MEMADR
          v(2'b00,2'b00,2'b00,2'b00,2'b01,1,0,0,0,1,0,0)};  // MEMWRITE stalled
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i < 3); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL rst_mid_pre cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    // Assert reset while MEMWRITE is still stalled; hold for 3 edges.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== v(2'b00,2'b00,2'b10,2'b10,2'b01,0,0,0,0,0,0,0)) begin
        errors++; $display("FAIL rst_mid_hold cyc%0d obs=%b exp=%b MemWrite=%b", i, obs,
                           v(2'b00,2'b00,2'b10,2'b10,2'b01,0,0,0,0,0,0,0), MemWrite);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if (obs !== v(2'b00,2'b00,2'b10,2'b10,2'b01,0,1,1,0,0,0,0)) begin
      errors++; $display("FAIL rst_mid_release obs=%b exp=%b", obs, v(2'b00,2'b00,2'b10,2'b10,2'b01,0,1,1,0,0,0,0));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_itype();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw_stall();
    test_jal();
    test_illegal();
    test_reset_mid_write();
    test_lw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
